bf_dot_seq: RTL

//  Upstream sequencer for the bfloat16 MAC. Accepts a stream of bf16 operand pairs
//  (valid/ready), clears the MAC accumulator at the start of each vector, issues
//  one mac_en per pair, waits for the MAC to settle, then returns the bf16 dot

---
 rtl/bf_dot_seq_if.sv | 46 ++++
 rtl/bf_dot_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bf_dot_seq_if.sv
// bf_dot_seq_if
//   Groups every bus of the bfloat16 dot-product sequencer into one bundle.
//   The command, operand, MAC and result signals all live here.
//   The slave modport is the sequencer's view of the bundle.
//   The master modport is the view of the surrounding logic: the operand
//   source, the MAC and the result consumer.
//
//   Ports (sequencer view):
//     start, vec_len                 in   command: begin a vector of vec_len pairs
//     busy                           out  sequencer not idle
//     op_a, op_b, op_valid           in   bf16 operand pair stream
//     op_ready                       out  operand pair accepted on valid & ready
//     mac_in_1, mac_in_2             out  registered operands to the MAC
//     mac_en, mac_clr                out  MAC accumulate strobe / accumulator clear
//     mac_acc                        in   MAC accumulator value
//     res_data, res_valid            out  bf16 dot product
//     res_ready                      in   result consumer ready
interface bf_dot_seq_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic             busy;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic             op_valid;
  logic             op_ready;
  logic [15:0]      mac_in_1;
  logic [15:0]      mac_in_2;
  logic             mac_en;
  logic             mac_clr;
  logic [15:0]      mac_acc;
  logic [15:0]      res_data;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output start, vec_len, op_a, op_b, op_valid, mac_acc, res_ready,
    input  busy, op_ready, mac_in_1, mac_in_2, mac_en, mac_clr, res_data, res_valid
  );

  modport slave (
    input  start, vec_len, op_a, op_b, op_valid, mac_acc, res_ready,
    output busy, op_ready, mac_in_1, mac_in_2, mac_en, mac_clr, res_data, res_valid
  );
endinterface

// File: rtl/bf_dot_seq.sv
// bf_dot_seq
//   Upstream sequencer for a bfloat16 MAC. It runs one vector at a time:
//     1. Clear the MAC accumulator.
//     2. Feed each operand pair to the MAC with a single-cycle mac_en.
//     3. Wait for the MAC to settle.
//     4. Hold the accumulator value on a valid/ready result port.
//   This block does no arithmetic. The result is the mac_acc value, bit for bit.
//
//   Parameters:
//     LEN_W    width of vec_len and the beat counter
//     MAC_LAT  MAC latency from mac_en high to mac_acc updated (>= 1)
//
//   Ports:
//     clk   in  clock, rising edge
//     rst   in  synchronous reset, active low
//     bus   --  bf_dot_seq_if.slave (command, operand, MAC and result signals)
module bf_dot_seq #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  bf_dot_seq_if.slave  bus
);

  localparam int WAIT_W = $clog2(MAC_LAT + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    OUT
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              handshake;
  logic              last_beat;
  logic              drain_done;

  // op_ready is a function of the state alone, so a handshake is just
  // op_valid seen while feeding.
  always_comb begin
    handshake  = (state == FEED) && bus.op_valid;
    last_beat  = handshake && (cnt == len - LEN_W'(1));
    drain_done = (state == DRAIN) && (wait_cnt == WAIT_W'(MAC_LAT));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. All status and strobe outputs except mac_en are
  // decoded from the current state.
  always_comb begin
    next_state    = state;
    bus.busy      = (state != IDLE);
    bus.op_ready  = (state == FEED);
    bus.mac_clr   = (state == CLEAR);
    bus.res_valid = (state == OUT);
    case (state)
      IDLE: begin
        // A zero-length vector has a zero dot product.
        // It goes straight to OUT and leaves the MAC untouched.
        if (bus.start) begin
          next_state = (bus.vec_len != '0) ? CLEAR : OUT;
        end
      end
      CLEAR: next_state = FEED;
      FEED: begin
        if (last_beat) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          next_state = OUT;
        end
      end
      OUT: begin
        if (bus.res_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers.
  // - mac_en is the registered handshake. Each accepted pair therefore gives
  //   exactly one strobe, one cycle later, together with its operands.
  // - DRAIN lasts MAC_LAT+1 cycles. That covers the last mac_en plus the MAC
  //   latency before mac_acc is captured.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.mac_in_1 <= 16'h0000;
      bus.mac_in_2 <= 16'h0000;
      bus.mac_en   <= 1'b0;
      bus.res_data <= 16'h0000;
      len          <= '0;
      cnt          <= '0;
      wait_cnt     <= '0;
    end else begin
      bus.mac_en <= handshake;
      if (handshake) begin
        bus.mac_in_1 <= bus.op_a;
        bus.mac_in_2 <= bus.op_b;
        cnt          <= cnt + LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            len <= bus.vec_len;
            cnt <= '0;
            if (bus.vec_len == '0) begin
              bus.res_data <= 16'h0000;
            end
          end
        end
        FEED: begin
          if (last_beat) begin
            wait_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            bus.res_data <= bus.mac_acc;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
